// File: rtl/shift8_ctrl.sv
// Multi-cycle 8-bit shifter: one 1-bit step of the latched op per clock, Moore FSM IDLE/SHIFT/DONE.
// A companion checker module holds the protocol assertions.
module shift8_ctrl (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       start,
    input  logic [1:0] op,
    input  logic [2:0] amount,
    input  logic [7:0] d_in,
    output logic [7:0] q,
    output logic       busy,
    output logic       done
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam logic [1:0] OP_LSL = 2'd0;
    localparam logic [1:0] OP_LSR = 2'd1;
    localparam logic [1:0] OP_ASR = 2'd2;
    localparam logic [1:0] OP_ROR = 2'd3;

    state_t      state_r;
    state_t      state_next_s;
    logic [7:0]  q_r;
    logic [7:0]  q_next_s;
    logic [2:0]  cnt_r;
    logic [2:0]  cnt_next_s;
    logic [1:0]  op_r;
    logic [1:0]  op_next_s;
    logic        busy_s;
    logic        done_s;

    function automatic logic [7:0] shift_step(input logic [7:0] v, input logic [1:0] kind);
        logic [7:0] r;
        case (kind)
            OP_LSL:  r = {v[6:0], 1'b0};
            OP_LSR:  r = {1'b0, v[7:1]};
            OP_ASR:  r = {v[7], v[7:1]};
            OP_ROR:  r = {v[0], v[7:1]};
            default: r = v;
        endcase
        return r;
    endfunction

    // State and datapath registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r <= IDLE;
            q_r     <= 8'h00;
            cnt_r   <= 3'd0;
            op_r    <= 2'd0;
        end else begin
            state_r <= state_next_s;
            q_r     <= q_next_s;
            cnt_r   <= cnt_next_s;
            op_r    <= op_next_s;
        end
    end

    // Next-state logic; the unused encoding falls back to IDLE
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            IDLE: begin
                if (start) begin
                    state_next_s = (amount != 3'd0) ? SHIFT : DONE;
                end else begin
                    state_next_s = IDLE;
                end
            end
            SHIFT: begin
                if (cnt_r == 3'd1) begin
                    state_next_s = DONE;
                end else begin
                    state_next_s = SHIFT;
                end
            end
            DONE:    state_next_s = IDLE;
            default: state_next_s = IDLE;
        endcase
    end

    // Datapath next values: inputs are only looked at when a start is accepted in IDLE
    always_comb begin
        q_next_s   = q_r;
        cnt_next_s = cnt_r;
        op_next_s  = op_r;
        case (state_r)
            IDLE: begin
                if (start) begin
                    q_next_s   = d_in;
                    cnt_next_s = amount;
                    op_next_s  = op;
                end else begin
                    q_next_s   = q_r;
                end
            end
            SHIFT: begin
                q_next_s   = shift_step(q_r, op_r);
                cnt_next_s = cnt_r - 3'd1;
            end
            DONE:    q_next_s = q_r;
            default: q_next_s = q_r;
        endcase
    end

    // Moore output decode
    always_comb begin
        busy_s = 1'b0;
        done_s = 1'b0;
        case (state_r)
            SHIFT:   busy_s = 1'b1;
            DONE:    done_s = 1'b1;
            default: begin
                busy_s = 1'b0;
                done_s = 1'b0;
            end
        endcase
    end

    assign q    = q_r;
    assign busy = busy_s;
    assign done = done_s;

    shift8_ctrl_chk u_chk (
        .clk     (clk),
        .reset_n (reset_n),
        .busy    (busy_s),
        .done    (done_s),
        .cnt     (cnt_r)
    );

endmodule

// Protocol assertions for shift8_ctrl.
module shift8_ctrl_chk (
    input logic       clk,
    input logic       reset_n,
    input logic       busy,
    input logic       done,
    input logic [2:0] cnt
);

    a_busy_done_excl: assert property (@(posedge clk) disable iff (!reset_n) !(busy && done));

    // While stepping the counter never reaches zero, it leaves SHIFT on the step from 1
    a_cnt_nonzero: assert property (@(posedge clk) disable iff (!reset_n) busy |-> (cnt != 3'd0));

    a_done_single: assert property (@(posedge clk) disable iff (!reset_n) done |=> !done);

endmodule

// File: tb/tb_shift8_ctrl.sv
// Directed self-checking bench for shift8_ctrl.
module tb_shift8_ctrl;

    logic       clk;
    logic       reset_n;
    logic       start;
    logic [1:0] op;
    logic [2:0] amount;
    logic [7:0] d_in;
    logic [7:0] q;
    logic       busy;
    logic       done;

    int n_checks;
    int n_fail;

    shift8_ctrl dut (
        .clk     (clk),
        .reset_n (reset_n),
        .start   (start),
        .op      (op),
        .amount  (amount),
        .d_in    (d_in),
        .q       (q),
        .busy    (busy),
        .done    (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset_n = 1'b1;
        start   = 1'b0;
        op      = 2'd0;
        amount  = 3'd0;
        d_in    = 8'h00;
        #1;
        reset_n = 1'b0;
        start   = 1'($urandom);
        op      = 2'($urandom);
        amount  = 3'($urandom);
        d_in    = 8'($urandom);
        #1;
        n_checks++;
        if (q !== 8'h00 || busy !== 1'b0 || done !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_async: q=%h busy=%b done=%b, want q=00 busy=0 done=0", q, busy, done);
        end
        tick();
        tick();
        start = 1'b0;
        reset_n = 1'b1;
        tick();
        tick();
        n_checks++;
        if (q !== 8'h00 || busy !== 1'b0 || done !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_hold: q=%h busy=%b done=%b, want q=00 busy=0 done=0", q, busy, done);
        end
    endtask

    // Runs one operation; the start edge is the first tick, then N steps and one IDLE cycle
    task automatic run_op(input logic [1:0] k, input logic [7:0] d, input logic [2:0] n,
                          input logic [7:0] exp_q, input string name);
        int busy_cnt;
        int done_cnt;
        busy_cnt = 0;
        done_cnt = 0;
        start  = 1'b1;
        op     = k;
        d_in   = d;
        amount = n;
        tick();
        start  = 1'b0;
        d_in   = ~d;
        op     = ~k;
        n_checks++;
        if (q !== d) begin
            n_fail++;
            $display("FAIL %s_load: q=%h want %h", name, q, d);
        end
        for (int i = 0; i < 8; i++) begin
            if (busy === 1'b1) busy_cnt++;
            if (done === 1'b1) done_cnt++;
            if (done === 1'b1) break;
            tick();
        end
        n_checks++;
        if (q !== exp_q || done !== 1'b1 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL %s_result: q=%h done=%b busy=%b want q=%h done=1 busy=0",
                     name, q, done, busy, exp_q);
        end
        n_checks++;
        if (busy_cnt != int'(n) || done_cnt != 1) begin
            n_fail++;
            $display("FAIL %s_timing: busy_cycles=%0d done_cycles=%0d want %0d and 1",
                     name, busy_cnt, done_cnt, n);
        end
        tick();
        tick();
        n_checks++;
        if (q !== exp_q || done !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL %s_idle_hold: q=%h done=%b busy=%b want q=%h done=0 busy=0",
                     name, q, done, busy, exp_q);
        end
    endtask

    task automatic test_lsl();
        start = 1'b1; op = 2'd0; d_in = 8'hAA; amount = 3'd1;
        tick();
        start = 1'b0;
        n_checks++;
        if (q !== 8'hAA || busy !== 1'b1 || done !== 1'b0) begin
            n_fail++;
            $display("FAIL lsl_step0: q=%h busy=%b done=%b want AA 1 0", q, busy, done);
        end
        tick();
        n_checks++;
        if (q !== 8'h54 || busy !== 1'b0 || done !== 1'b1) begin
            n_fail++;
            $display("FAIL lsl_step1: q=%h busy=%b done=%b want 54 0 1", q, busy, done);
        end
        tick();
        n_checks++;
        if (q !== 8'h54 || busy !== 1'b0 || done !== 1'b0) begin
            n_fail++;
            $display("FAIL lsl_idle: q=%h busy=%b done=%b want 54 0 0", q, busy, done);
        end
    endtask

    task automatic test_asr();
        logic [7:0] exp_seq [4];
        exp_seq[0] = 8'hF0; exp_seq[1] = 8'hF8; exp_seq[2] = 8'hFC; exp_seq[3] = 8'hFE;
        start = 1'b1; op = 2'd2; d_in = 8'hF0; amount = 3'd3;
        tick();
        start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            n_checks++;
            if (q !== exp_seq[i] || busy !== (i < 3) || done !== (i == 3)) begin
                n_fail++;
                $display("FAIL asr_seq%0d: q=%h busy=%b done=%b want q=%h busy=%b done=%b",
                         i, q, busy, done, exp_seq[i], (i < 3), (i == 3));
            end
            tick();
        end
        n_checks++;
        if (q !== 8'hFE || busy !== 1'b0 || done !== 1'b0) begin
            n_fail++;
            $display("FAIL asr_idle: q=%h busy=%b done=%b want FE 0 0", q, busy, done);
        end
    endtask

    task automatic test_amount_zero();
        start = 1'b1; op = 2'd3; d_in = 8'h5A; amount = 3'd0;
        tick();
        start = 1'b0;
        n_checks++;
        if (q !== 8'h5A || busy !== 1'b0 || done !== 1'b1) begin
            n_fail++;
            $display("FAIL zero_done: q=%h busy=%b done=%b want 5A 0 1", q, busy, done);
        end
        tick();
        n_checks++;
        if (q !== 8'h5A || busy !== 1'b0 || done !== 1'b0) begin
            n_fail++;
            $display("FAIL zero_idle: q=%h busy=%b done=%b want 5A 0 0", q, busy, done);
        end
    endtask

    task automatic test_back_to_back();
        int done_cnt;
        done_cnt = 0;
        start = 1'b1; op = 2'd3; d_in = 8'h81; amount = 3'd4;
        tick();
        // Edges k+1..k+5: churn every input while start stays high
        for (int i = 0; i < 5; i++) begin
            d_in   = 8'($urandom);
            op     = 2'($urandom);
            amount = 3'($urandom);
            tick();
            if (done === 1'b1) done_cnt++;
            if (i == 3) begin
                n_checks++;
                if (q !== 8'h18 || done !== 1'b1) begin
                    n_fail++;
                    $display("FAIL held_result: q=%h done=%b want 18 1", q, done);
                end
            end
        end
        n_checks++;
        if (done_cnt != 1 || q !== 8'h18 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL held_single_done: done_pulses=%0d q=%h busy=%b want 1 18 0",
                     done_cnt, q, busy);
        end
        op = 2'd0; d_in = 8'h3C; amount = 3'd1;
        tick();
        n_checks++;
        if (q !== 8'h3C || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL b2b_accept: q=%h busy=%b want 3C 1", q, busy);
        end
        start = 1'b0;
        tick();
        n_checks++;
        if (q !== 8'h78 || done !== 1'b1) begin
            n_fail++;
            $display("FAIL b2b_result: q=%h done=%b want 78 1", q, done);
        end
        tick();
    endtask

    task automatic test_reset_mid();
        int done_cnt;
        done_cnt = 0;
        start = 1'b1; op = 2'd1; d_in = 8'hFF; amount = 3'd6;
        tick();
        start = 1'b0;
        tick();
        tick();
        n_checks++;
        if (q !== 8'h3F || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL rstmid_pre: q=%h busy=%b want 3F 1", q, busy);
        end
        #2;
        reset_n = 1'b0;
        #1;
        n_checks++;
        if (q !== 8'h00 || busy !== 1'b0 || done !== 1'b0) begin
            n_fail++;
            $display("FAIL rstmid_async: q=%h busy=%b done=%b want 00 0 0", q, busy, done);
        end
        tick();
        if (done === 1'b1) done_cnt++;
        // Release with start already high: the first edge afterwards must be accepted
        start = 1'b1; op = 2'd0; d_in = 8'h01; amount = 3'd2;
        reset_n = 1'b1;
        tick();
        if (done === 1'b1) done_cnt++;
        start = 1'b0;
        n_checks++;
        if (q !== 8'h01 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL rstmid_accept: q=%h busy=%b want 01 1", q, busy);
        end
        tick();
        if (done === 1'b1) done_cnt++;
        n_checks++;
        if (done_cnt != 0) begin
            n_fail++;
            $display("FAIL rstmid_no_done: done_pulses=%0d want 0", done_cnt);
        end
        tick();
        n_checks++;
        if (q !== 8'h04 || done !== 1'b1 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL rstmid_next: q=%h done=%b busy=%b want 04 1 0", q, done, busy);
        end
        tick();
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        test_reset();
        test_lsl();
        test_asr();
        run_op(2'd3, 8'hCC, 3'd2, 8'h33, "ror_cc");
        run_op(2'd1, 8'h80, 3'd7, 8'h01, "lsr_80");
        run_op(2'd2, 8'h40, 3'd2, 8'h10, "asr_pos");
        test_amount_zero();
        test_back_to_back();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL timeout: simulation exceeded 20000 time units");
        $fatal(1);
    end

endmodule
